uart_rx_oversample: RTL

- UART serial receiver; sits directly downstream of the baud-rate tick generator and consumes its one-clock `rate` pulse as `s_tick`, which is 16x oversampling of the bit rate.
- Synchronises the `rx` line, detects the start bit, samples each bit at mid-point and assembles an 8N1 frame.
- Holds the received byte in a one-deep output register with a valid/read handshake and error flags for the downstream interface FSM.

---
 rtl/uart_rx_oversample.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_rx_oversample.sv
// 8N1-style UART receiver driven by a 16x oversampling tick, with a one-deep
// output register, valid/read handshake, framing-error and sticky overrun flags.
module uart_rx_oversample #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rd,
  output logic [DBIT-1:0] dout,
  output logic            data_valid,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            overrun
);

  // Tick counter widens only when a 1.5/2 stop-bit setting needs more than 16 ticks.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            rx_meta, rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else begin
      state <= state_next;
      s     <= s_next;
      n     <= n_next;
      b     <= b_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == SW'(7)) begin
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_next = '0;
            b_next = DBIT'({rx_s, b} >> 1);
            if (n == NW'(DBIT - 1)) state_next = STOP;
            else                    n_next     = n + 1'b1;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == SW'(SB_TICK - 1)) state_next = IDLE;
          else                       s_next     = s + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_done_tick = (state == STOP) && s_tick && (s == SW'(SB_TICK - 1));
  end

  // A read in the completion cycle consumes the old byte, so no overrun is flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (rx_done_tick) begin
      dout       <= b;
      data_valid <= 1'b1;
      frame_err  <= ~rx_s;
      if (data_valid && !rd) overrun <= 1'b1;
    end else if (rd) begin
      data_valid <= 1'b0;
    end
  end

endmodule
